// File: rtl/ram_shim_pkg.sv
// Shared opcodes, command width and FSM state encoding for the ram_shim_dma bridge.
package ram_shim_pkg;

  localparam int RAM_SHIM_CMD_WID = 2;

  localparam logic [RAM_SHIM_CMD_WID-1:0] RAM_SHIM_SET_BASE   = 2'b00;
  localparam logic [RAM_SHIM_CMD_WID-1:0] RAM_SHIM_READ_PTR   = 2'b01;
  localparam logic [RAM_SHIM_CMD_WID-1:0] RAM_SHIM_RESET_PTR  = 2'b10;
  localparam logic [RAM_SHIM_CMD_WID-1:0] RAM_SHIM_READ_COUNT = 2'b11;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_WR_LO,
    ST_WAIT_LO,
    ST_WR_HI,
    ST_WAIT_HI,
    ST_DONE,
    ST_CMD_DONE
  } ram_shim_state_t;

endpackage

// File: rtl/ram_word_writer.sv
// One RAM word write: start loads word/addr and raises write; write drops on valid.
// Latency 1 cycle from start to write; holds word/addr/write until the RAM acknowledges.
module ram_word_writer #(
  parameter int RAM_WORD = 16,
  parameter int RAM_WID  = 32
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                start,
  input  logic [RAM_WORD-1:0] start_word,
  input  logic [RAM_WID-1:0]  start_addr,
  input  logic                valid,
  output logic                write,
  output logic [RAM_WORD-1:0] word,
  output logic [RAM_WID-1:0]  addr,
  output logic                ack
);

  assign ack = write & valid;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      write <= 1'b0;
      word  <= '0;
      addr  <= '0;
    end else if (start) begin
      write <= 1'b1;
      word  <= start_word;
      addr  <= start_addr;
    end else if (ack) begin
      write <= 1'b0;
    end
  end

endmodule

// File: rtl/ram_shim_dma.sv
// Sample-to-RAM bridge: each sample is sign-extended and written as two words, low first, plus a pointer command port.
// Optional RAM_SHIM_SAMPLE_COUNT_EN adds a committed-sample counter readable with opcode 11.
module ram_shim_dma
  import ram_shim_pkg::*;
#(
  parameter int DAT_WID  = 24,
  parameter int RAM_WORD = 16,
  parameter int RAM_WID  = 32
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic [DAT_WID-1:0]          data,
  input  logic                        data_commit,
  output logic                        finished,
  output logic [RAM_WORD-1:0]         word,
  output logic [RAM_WID-1:0]          addr,
  output logic                        write,
  input  logic                        valid,
  input  logic [RAM_WID-1:0]          cmd_data,
  input  logic [RAM_SHIM_CMD_WID-1:0] cmd,
  input  logic                        cmd_active,
  output logic                        cmd_finished,
  output logic [RAM_WID-1:0]          cmd_data_out
);

  localparam int SAMP_W = 2 * RAM_WORD;
  localparam logic [RAM_WID-1:0] HALF_STEP = RAM_WID'(RAM_WORD / 8);
  localparam logic [RAM_WID-1:0] FULL_STEP = RAM_WID'(SAMP_W / 8);

  ram_shim_state_t     state;
  logic [RAM_WID-1:0]  base;
  logic [RAM_WID-1:0]  ptr;
  logic [RAM_WORD-1:0] samp_hi;
  logic [SAMP_W-1:0]   samp_in;
  logic                wr_start;
  logic                wr_ack;
  logic [RAM_WORD-1:0] wr_word;
  logic [RAM_WID-1:0]  wr_addr;
  logic [RAM_WID-1:0]  cnt_val;
  logic                cmd_go;

  assign samp_in = SAMP_W'(signed'(data));
  assign cmd_go  = (state == ST_IDLE) && cmd_active;

  // The high word only launches once the low acknowledge has been released.
  assign wr_start = ((state == ST_IDLE) && data_commit && !cmd_active) ||
                    ((state == ST_WAIT_LO) && !valid);
  assign wr_word  = (state == ST_IDLE) ? samp_in[RAM_WORD-1:0] : samp_hi;
  assign wr_addr  = (state == ST_IDLE) ? ptr : ptr + HALF_STEP;

  ram_word_writer #(.RAM_WORD(RAM_WORD), .RAM_WID(RAM_WID)) u_writer (
    .clk        (clk),
    .rst_n      (rst_n),
    .start      (wr_start),
    .start_word (wr_word),
    .start_addr (wr_addr),
    .valid      (valid),
    .write      (write),
    .word       (word),
    .addr       (addr),
    .ack        (wr_ack)
  );

`ifdef RAM_SHIM_SAMPLE_COUNT_EN
  logic [RAM_WID-1:0] count;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count <= '0;
    end else if (cmd_go && (cmd == RAM_SHIM_SET_BASE || cmd == RAM_SHIM_RESET_PTR)) begin
      count <= '0;
    end else if ((state == ST_WAIT_HI) && !valid) begin
      count <= count + 1'b1;
    end
  end

  assign cnt_val = count;
`else
  assign cnt_val = '0;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= ST_IDLE;
      base         <= '0;
      ptr          <= '0;
      samp_hi      <= '0;
      finished     <= 1'b0;
      cmd_finished <= 1'b0;
      cmd_data_out <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (cmd_active) begin
            cmd_finished <= 1'b1;
            state        <= ST_CMD_DONE;
            case (cmd)
              RAM_SHIM_SET_BASE: begin
                base         <= cmd_data;
                ptr          <= cmd_data;
                cmd_data_out <= cmd_data;
              end
              RAM_SHIM_READ_PTR:  cmd_data_out <= ptr;
              RAM_SHIM_RESET_PTR: begin
                ptr          <= base;
                cmd_data_out <= base;
              end
              default:            cmd_data_out <= cnt_val;
            endcase
          end else if (data_commit) begin
            samp_hi <= samp_in[SAMP_W-1:RAM_WORD];
            state   <= ST_WR_LO;
          end
        end
        ST_WR_LO:   if (wr_ack) state <= ST_WAIT_LO;
        ST_WAIT_LO: if (!valid) state <= ST_WR_HI;
        ST_WR_HI: begin
          if (wr_ack) begin
            ptr   <= ptr + FULL_STEP;
            state <= ST_WAIT_HI;
          end
        end
        ST_WAIT_HI: begin
          if (!valid) begin
            finished <= 1'b1;
            state    <= ST_DONE;
          end
        end
        ST_DONE: begin
          if (!data_commit) begin
            finished <= 1'b0;
            state    <= ST_IDLE;
          end
        end
        ST_CMD_DONE: begin
          if (!cmd_active) begin
            cmd_finished <= 1'b0;
            state        <= ST_IDLE;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_ram_shim_dma.sv
// Directed bench for ram_shim_dma: RAM responder pops an expected-write scoreboard, command results checked against a pointer model.
module tb_ram_shim_dma;
  import ram_shim_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [23:0] data;
  logic        data_commit;
  logic        finished;
  logic [15:0] word;
  logic [31:0] addr;
  logic        write;
  logic        valid;
  logic [31:0] cmd_data;
  logic [1:0]  cmd;
  logic        cmd_active;
  logic        cmd_finished;
  logic [31:0] cmd_data_out;

  int          errors = 0;
  int          checks = 0;
  int          ack_dly = 3;
  int          rel_dly = 1;
  logic [47:0] exp_q[$];
  logic [31:0] mptr;
  logic [31:0] exp_count;

  ram_shim_dma dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .data         (data),
    .data_commit  (data_commit),
    .finished     (finished),
    .word         (word),
    .addr         (addr),
    .write        (write),
    .valid        (valid),
    .cmd_data     (cmd_data),
    .cmd          (cmd),
    .cmd_active   (cmd_active),
    .cmd_finished (cmd_finished),
    .cmd_data_out (cmd_data_out)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic push_sample(input logic [23:0] d);
    logic [31:0] sx;
    sx = {{8{d[23]}}, d};
    exp_q.push_back({mptr, sx[15:0]});
    exp_q.push_back({mptr + 32'd2, sx[31:16]});
    mptr = mptr + 32'd4;
  endtask

  task automatic do_cmd(input logic [1:0] op, input logic [31:0] arg,
                        input logic [31:0] exp, input string tag);
    int n = 0;
    @(negedge clk);
    cmd = op; cmd_data = arg; cmd_active = 1'b1;
    while (!cmd_finished && n < 100) begin @(negedge clk); n++; end
    check({tag, "_fin"}, cmd_finished, 1);
    check(tag, cmd_data_out, exp);
    cmd = ~op; cmd_data = ~arg;
    @(negedge clk);
    check({tag, "_ignore_change"}, cmd_data_out, exp);
    cmd_active = 1'b0;
    n = 0;
    while (cmd_finished && n < 100) begin @(negedge clk); n++; end
    check({tag, "_fin_clr"}, cmd_finished, 0);
    check({tag, "_hold"}, cmd_data_out, exp);
  endtask

  task automatic do_sample(input logic [23:0] d);
    int n = 1;
    push_sample(d);
    @(negedge clk);
    data = d; data_commit = 1'b1;
    @(negedge clk);
    data = 24'($urandom);
    while (!finished && n < 200) begin @(negedge clk); n++; end
    check("finished", finished, 1);
    check("finish_latency_ge5", n >= 5, 1);
    check("sample_drained", exp_q.size(), 0);
    data_commit = 1'b0;
    n = 0;
    while (finished && n < 100) begin @(negedge clk); n++; end
    check("finished_clr", finished, 0);
  endtask

  // RAM model: acknowledge ack_dly cycles after write, release rel_dly cycles after write drops.
  initial begin : ram
    logic [47:0] e;
    int n;
    valid = 1'b0;
    forever begin
      @(posedge clk); #1;
      if (write) begin
        repeat (ack_dly) @(posedge clk);
        #1;
        if (write) begin
          check("scoreboard_nonempty", exp_q.size() > 0, 1);
          if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            check("ram_addr", addr, e[47:16]);
            check("ram_word", {16'h0, word}, {16'h0, e[15:0]});
          end
          valid = 1'b1;
          n = 0;
          while (write && n < 50) begin @(posedge clk); #1; n++; end
          check("write_released", write, 0);
          for (int i = 0; i < rel_dly; i++) begin
            @(posedge clk); #1;
            check("no_write_while_valid", write, 0);
          end
          valid = 1'b0;
        end
      end
    end
  end

  initial begin : watchdog
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "time limit");
  end

  initial begin : stim
    int n;
    int stall_seen;
    rst_n = 1'b0; data = '0; data_commit = 1'b0;
    cmd_data = '0; cmd = '0; cmd_active = 1'b0;
    mptr = 32'h0;
    #12;
    check("rst_write", write, 0);
    check("rst_finished", finished, 0);
    check("rst_cmd_finished", cmd_finished, 0);
    check("rst_cmd_data_out", cmd_data_out, 0);
    check("rst_addr", addr, 0);
    check("rst_word", {16'h0, word}, 0);
    @(negedge clk);
    rst_n = 1'b1;

    do_cmd(RAM_SHIM_SET_BASE, 32'h1000, 32'h1000, "set_base");
    mptr = 32'h1000;
    do_cmd(RAM_SHIM_READ_PTR, 32'h0, 32'h1000, "read_ptr0");

    do_sample(24'h800001);
    do_cmd(RAM_SHIM_READ_PTR, 32'h0, mptr, "read_ptr1");

    do_sample(24'h000005);
    do_sample(24'h7FFFFF);
    do_sample(24'hFFFFFF);
    do_cmd(RAM_SHIM_READ_PTR, 32'h0, mptr, "read_ptr4");
`ifdef RAM_SHIM_SAMPLE_COUNT_EN
    exp_count = 32'd4;
`else
    exp_count = 32'd0;
`endif
    do_cmd(RAM_SHIM_READ_COUNT, 32'h0, exp_count, "read_count");

    // Command raised while the low word waits on valid must stall behind the sample.
    push_sample(24'h123456);
    @(negedge clk);
    data = 24'h123456; data_commit = 1'b1;
    @(negedge clk);
    @(negedge clk);
    cmd = RAM_SHIM_READ_PTR; cmd_active = 1'b1;
    n = 0; stall_seen = 0;
    while (!finished && n < 200) begin
      @(negedge clk); n++;
      if (cmd_finished) stall_seen++;
    end
    check("cmd_stalled", stall_seen, 0);
    check("stall_finished", finished, 1);
    check("stall_drained", exp_q.size(), 0);
    data_commit = 1'b0;
    n = 0;
    while (!cmd_finished && n < 100) begin @(negedge clk); n++; end
    check("stall_cmd_fin", cmd_finished, 1);
    check("stall_cmd_ptr", cmd_data_out, mptr);
    cmd_active = 1'b0;
    n = 0;
    while (cmd_finished && n < 100) begin @(negedge clk); n++; end
    check("stall_cmd_clr", cmd_finished, 0);

    do_cmd(RAM_SHIM_SET_BASE, 32'hFFFF_FFFC, 32'hFFFF_FFFC, "set_base_wrap");
    mptr = 32'hFFFF_FFFC;
    do_sample(24'h0ABCDE);
    do_cmd(RAM_SHIM_READ_PTR, 32'h0, 32'h0, "read_ptr_wrap");

    // Reset while waiting for the low acknowledge to release.
    do_cmd(RAM_SHIM_SET_BASE, 32'h2000, 32'h2000, "set_base_rst");
    mptr = 32'h2000;
    rel_dly = 4;
    push_sample(24'hABCDEF);
    @(negedge clk);
    data = 24'hABCDEF; data_commit = 1'b1;
    n = 0;
    while (!write && n < 20) begin @(negedge clk); n++; end
    n = 0;
    while (write && n < 50) begin @(negedge clk); n++; end
    #2 rst_n = 1'b0;
    #1;
    check("mid_rst_write", write, 0);
    check("mid_rst_finished", finished, 0);
    check("mid_rst_addr", addr, 0);
    check("stale_entry", exp_q.size(), 1);
    exp_q.delete();
    data_commit = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (6) @(negedge clk);
    check("post_rst_no_write", write, 0);
    do_cmd(RAM_SHIM_READ_PTR, 32'h0, 32'h0, "read_ptr_rst");
    do_cmd(RAM_SHIM_RESET_PTR, 32'h0, 32'h0, "reset_ptr_rst");
    do_cmd(RAM_SHIM_READ_COUNT, 32'h0, 32'h0, "read_count_rst");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/ram_shim_dma.md
Name: ram_shim_dma

Overview:
- Bridge between a sample producer (the raster scan engine) and a word-wide DMA/RAM write port.
- Each committed DAT_WID-bit sample is sign-extended to 2*RAM_WORD bits and written as two RAM words, low word first, to consecutive byte addresses.
- A small command port sets, reads and rewinds the write pointer.

Parameters:
- DAT_WID, 24, sample width; must satisfy DAT_WID <= 2*RAM_WORD.
- RAM_WORD, 16, RAM data word width in bits; must be a multiple of 8.
- RAM_WID, 32, RAM byte-address width and command data width.

Ports:
- clk  in  1  system clock.
- rst_n  in  1  asynchronous active-low reset.
- data  in  DAT_WID  signed sample, sampled when a commit is accepted.
- data_commit  in  1  producer request; held high until finished is seen.
- finished  out  1  sample fully stored; held until data_commit drops.
- word  out  RAM_WORD  RAM write data.
- addr  out  RAM_WID  RAM byte address.
- write  out  1  RAM write request.
- valid  in  1  RAM write acknowledge.
- cmd_data  in  RAM_WID  command argument.
- cmd  in  RAM_SHIM_CMD_WID  command opcode.
- cmd_active  in  1  command request.
- cmd_finished  out  1  command done; held until cmd_active drops.
- cmd_data_out  out  RAM_WID  command result.

Behaviour:
- Reset: all outputs 0; base=0; ptr=0; state IDLE.
- Registers: base (RAM_WID), ptr (RAM_WID), sample latch (2*RAM_WORD).
- States: IDLE, WR_LO, WAIT_LO, WR_HI, WAIT_HI, DONE, CMD_DONE.
- IDLE, cmd_active=1: command wins over a simultaneous data_commit. Execute in one cycle, go to CMD_DONE.
  - cmd_finished=1 in CMD_DONE; return to IDLE the cycle after cmd_active=0, clearing cmd_finished.
  - cmd_data_out holds its value until the next command.
- IDLE, data_commit=1 (no cmd_active):
  - Latch sign-extended data.
  - Drive word=low half, addr=ptr, write=1; go to WR_LO.
- WR_LO: hold word/addr/write until valid=1, then write=0 and go to WAIT_LO.
- WAIT_LO: when valid=0, drive word=high half, addr=ptr+RAM_WORD/8, write=1; go to WR_HI.
  - This is a 4-phase handshake; a stale valid never acknowledges the next word.
- WR_HI: on valid=1, write=0, ptr += 2*RAM_WORD/8; go to WAIT_HI.
- WAIT_HI: when valid=0, finished=1; go to DONE.
- DONE: when data_commit=0, finished=0; go to IDLE.
- Minimum one sample = 2 RAM handshakes; finished rises no earlier than 5 cycles after commit.
- Commands asserted during a write are stalled (no cmd_finished) until the sample completes and the FSM returns to IDLE.
- ptr wraps modulo 2^RAM_WID; no overflow flag.
- cmd_active while cmd_finished is high and cmd is changed: ignored until the handshake completes.
- Reset mid-write: write drops immediately; the partial sample is discarded and ptr is not advanced.

Command opcodes, RAM_SHIM_CMD_WID=2:
- 00 SET_BASE: base=cmd_data, ptr=cmd_data, cmd_data_out=cmd_data.
- 01 READ_PTR: cmd_data_out=ptr.
- 10 RESET_PTR: ptr=base, cmd_data_out=base.
- 11 READ_COUNT: see Optional Feature.

Optional Feature:
- Macro RAM_SHIM_SAMPLE_COUNT_EN.
- Defined:
  - Adds a RAM_WID sample counter: cleared on reset, SET_BASE and RESET_PTR; incremented when a sample reaches DONE.
  - Opcode 11 returns the counter.
- Undefined: no counter; opcode 11 completes the handshake with cmd_data_out=0.

Decomposition:
- Package ram_shim_pkg:
  - RAM_SHIM_CMD_WID.
  - Opcode constants RAM_SHIM_SET_BASE, RAM_SHIM_READ_PTR, RAM_SHIM_RESET_PTR, RAM_SHIM_READ_COUNT.
  - FSM state enum.
- One natural sub-module: ram_word_writer, the single-word 4-phase write/valid handshake, instantiated once and sequenced twice per sample.

Test Plan:
- Reset, then SET_BASE cmd_data=0x1000 -> cmd_finished=1, cmd_data_out=0x1000; READ_PTR -> 0x1000.
- Commit data=0x800001 (negative) with RAM valid acked 3 cycles after each write -> (addr 0x1000, word 0x0001) then (0x1002, 0xFF80); finished=1; READ_PTR -> 0x1004.
- Three back-to-back commits of 0x000005, 0x7FFFFF, 0xFFFFFF -> words 0005/0000, FFFF/007F, FFFF/FFFF at 0x1004..0x100F; with RAM_SHIM_SAMPLE_COUNT_EN, READ_COUNT -> 4.
- Raise cmd_active=READ_PTR while waiting on valid in WR_LO -> no cmd_finished until the sample finishes; then cmd_data_out = pointer after the sample.
- SET_BASE 0xFFFFFFFC, commit one sample -> writes at 0xFFFFFFFC and 0xFFFFFFFE; READ_PTR -> 0x00000000.
- Assert rst_n=0 in WAIT_LO -> write/finished=0 immediately; READ_PTR after reset -> 0; RESET_PTR -> 0.
